vend_controller: RTL and testbench

//  Multi-product coin vending controller, parametrised in coin values, price, credit ceiling and product count.

---
 rtl/vend_controller.sv | 192 +++++++++++++++++++
 tb/tb_vend_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Coin vending controller: two coin denominations, credit ceiling, N_PROD stocked channels,
// greedy one-coin-per-cycle change return. All outputs are registered.
module vend_controller #(
    parameter int LO_VAL      = 1,
    parameter int HI_VAL      = 5,
    parameter int PRICE       = 2,
    parameter int MAX_CREDIT  = 10,
    parameter int N_PROD      = 2,
    parameter int STOCK_INIT  = 3,
    parameter int AUTO_CHANGE = 0,
    localparam int CW  = $clog2(MAX_CREDIT + 1),
    localparam int SW  = (N_PROD > 1) ? $clog2(N_PROD) : 1,
    localparam int STW = $clog2(STOCK_INIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              coin_valid,
    input  logic              coin_type,
    input  logic              vend_req,
    input  logic [SW-1:0]     vend_sel,
    input  logic              change_req,
    input  logic              restock,
    output logic [CW-1:0]     credit,
    output logic              vend_pulse,
    output logic [SW-1:0]     vend_id,
    output logic              vend_fail,
    output logic              coin_reject,
    output logic              ret_lo,
    output logic              ret_hi,
    output logic              busy,
    output logic [N_PROD-1:0] empty,
    output logic [15:0]       vend_total
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_VEND = 2'd1, ST_CHANGE = 2'd2} state_t;

    localparam logic [CW-1:0]  LO_C    = CW'(LO_VAL);
    localparam logic [CW-1:0]  HI_C    = CW'(HI_VAL);
    localparam logic [CW-1:0]  PRICE_C = CW'(PRICE);
    localparam logic [CW:0]    MAX_C   = (CW + 1)'(MAX_CREDIT);
    localparam logic [STW-1:0] INIT_C  = STW'(STOCK_INIT);

    state_t            state_r, state_s;
    logic [CW-1:0]     credit_r, credit_s;
    logic [STW-1:0]    stock_r [N_PROD];
    logic [STW-1:0]    stock_s [N_PROD];
    logic [N_PROD-1:0] empty_r, empty_s;
    logic [15:0]       total_r, total_s;
    logic [SW-1:0]     vend_id_r, vend_id_s;
    logic              vend_pulse_r, vend_pulse_s;
    logic              vend_fail_r, vend_fail_s;
    logic              coin_reject_r, coin_reject_s;
    logic              ret_lo_r, ret_lo_s;
    logic              ret_hi_r, ret_hi_s;
    logic              busy_r, busy_s;
    logic              sel_ok_s;
    logic [CW:0]       coin_sum_s;

    // Next-state, credit, stock and strobe computation.
    always_comb begin
        state_s       = state_r;
        credit_s      = credit_r;
        stock_s       = stock_r;
        total_s       = total_r;
        vend_id_s     = vend_id_r;
        vend_pulse_s  = 1'b0;
        vend_fail_s   = 1'b0;
        coin_reject_s = 1'b0;
        ret_lo_s      = 1'b0;
        ret_hi_s      = 1'b0;
        sel_ok_s      = (int'(vend_sel) < N_PROD);
        coin_sum_s    = {1'b0, credit_r} + {1'b0, (coin_type ? HI_C : LO_C)};

        case (state_r)
            ST_IDLE: begin
                if (change_req) begin
                    coin_reject_s = coin_valid;
                    if (credit_r != {CW{1'b0}}) begin
                        state_s = ST_CHANGE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (vend_req) begin
                    coin_reject_s = coin_valid;
                    if (sel_ok_s && (stock_r[vend_sel] != {STW{1'b0}}) && (credit_r >= PRICE_C)) begin
                        state_s           = ST_VEND;
                        vend_pulse_s      = 1'b1;
                        vend_id_s         = vend_sel;
                        credit_s          = credit_r - PRICE_C;
                        stock_s[vend_sel] = stock_r[vend_sel] - STW'(1);
                        total_s           = total_r + 16'd1;
                    end else begin
                        vend_fail_s = 1'b1;
                    end
                end else if (coin_valid) begin
                    // Ceiling is checked on the widened sum so the add itself never wraps.
                    if (coin_sum_s <= MAX_C) begin
                        credit_s = coin_sum_s[CW-1:0];
                    end else begin
                        coin_reject_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_VEND: begin
                coin_reject_s = coin_valid;
                if ((AUTO_CHANGE != 0) && (credit_r != {CW{1'b0}})) begin
                    state_s = ST_CHANGE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                coin_reject_s = coin_valid;
                if (credit_r == {CW{1'b0}}) begin
                    state_s = ST_IDLE;
                end else if (credit_r >= HI_C) begin
                    ret_hi_s = 1'b1;
                    credit_s = credit_r - HI_C;
                end else begin
                    ret_lo_s = 1'b1;
                    credit_s = credit_r - LO_C;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Restock overrides any decrement from a coincident vend.
        if (restock) begin
            for (int i = 0; i < N_PROD; i++) begin
                stock_s[i] = INIT_C;
            end
        end else begin
            stock_s = stock_s;
        end

        for (int i = 0; i < N_PROD; i++) begin
            empty_s[i] = (stock_s[i] == {STW{1'b0}});
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State and registered-output update; asynchronous reset discards any pending change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            credit_r      <= {CW{1'b0}};
            total_r       <= 16'd0;
            empty_r       <= {N_PROD{1'b0}};
            vend_id_r     <= {SW{1'b0}};
            vend_pulse_r  <= 1'b0;
            vend_fail_r   <= 1'b0;
            coin_reject_r <= 1'b0;
            ret_lo_r      <= 1'b0;
            ret_hi_r      <= 1'b0;
            busy_r        <= 1'b0;
            for (int i = 0; i < N_PROD; i++) begin
                stock_r[i] <= INIT_C;
            end
        end else begin
            state_r       <= state_s;
            credit_r      <= credit_s;
            total_r       <= total_s;
            empty_r       <= empty_s;
            vend_id_r     <= vend_id_s;
            vend_pulse_r  <= vend_pulse_s;
            vend_fail_r   <= vend_fail_s;
            coin_reject_r <= coin_reject_s;
            ret_lo_r      <= ret_lo_s;
            ret_hi_r      <= ret_hi_s;
            busy_r        <= busy_s;
            for (int i = 0; i < N_PROD; i++) begin
                stock_r[i] <= stock_s[i];
            end
        end
    end

    assign credit      = credit_r;
    assign vend_pulse  = vend_pulse_r;
    assign vend_id     = vend_id_r;
    assign vend_fail   = vend_fail_r;
    assign coin_reject = coin_reject_r;
    assign ret_lo      = ret_lo_r;
    assign ret_hi      = ret_hi_r;
    assign busy        = busy_r;
    assign empty       = empty_r;
    assign vend_total  = total_r;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: default instance plus an AUTO_CHANGE=1 instance on shared stimulus.
module tb_vend_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        coin_valid = 1'b0, coin_type = 1'b0, vend_req = 1'b0, change_req = 1'b0, restock = 1'b0;
    logic [0:0]  vend_sel = 1'b0;

    logic [3:0]  credit,      a_credit;
    logic        vend_pulse,  a_vend_pulse;
    logic [0:0]  vend_id,     a_vend_id;
    logic        vend_fail,   a_vend_fail;
    logic        coin_reject, a_coin_reject;
    logic        ret_lo,      a_ret_lo;
    logic        ret_hi,      a_ret_hi;
    logic        busy,        a_busy;
    logic [1:0]  empty,       a_empty;
    logic [15:0] vend_total,  a_vend_total;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vend_controller dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
        .vend_req(vend_req), .vend_sel(vend_sel), .change_req(change_req), .restock(restock),
        .credit(credit), .vend_pulse(vend_pulse), .vend_id(vend_id), .vend_fail(vend_fail),
        .coin_reject(coin_reject), .ret_lo(ret_lo), .ret_hi(ret_hi), .busy(busy),
        .empty(empty), .vend_total(vend_total)
    );

    vend_controller #(.AUTO_CHANGE(1)) dut_auto (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
        .vend_req(vend_req), .vend_sel(vend_sel), .change_req(change_req), .restock(restock),
        .credit(a_credit), .vend_pulse(a_vend_pulse), .vend_id(a_vend_id), .vend_fail(a_vend_fail),
        .coin_reject(a_coin_reject), .ret_lo(a_ret_lo), .ret_hi(a_ret_hi), .busy(a_busy),
        .empty(a_empty), .vend_total(a_vend_total)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        coin_valid = 1'b0; vend_req = 1'b0; change_req = 1'b0; restock = 1'b0;
    endtask

    task automatic coin(input logic hi);
        coin_valid = 1'b1; coin_type = hi;
        tick();
    endtask

    initial begin
        #12;
        check("rst_credit", credit, 0);
        check("rst_total", vend_total, 0);
        check("rst_empty", empty, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {vend_pulse, vend_fail, coin_reject, ret_lo, ret_hi, vend_id}, 0);
        reset = 1'b0;

        coin(1'b0); check("lo_coin_credit", credit, 1);
        coin(1'b1); check("hi_coin_credit", credit, 6);

        vend_sel = 1'b0; vend_req = 1'b1; tick();
        check("vend0_pulse", vend_pulse, 1);
        check("vend0_id", vend_id, 0);
        check("vend0_credit", credit, 4);
        check("vend0_busy", busy, 1);
        check("vend0_total", vend_total, 1);
        tick();
        check("vend0_end", {vend_pulse, busy}, 0);

        change_req = 1'b1; tick();
        check("chg4_enter", {busy, ret_lo, ret_hi}, 3'b100);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("chg4_step", {busy, ret_lo, ret_hi, credit}, {3'b110, 4'(3 - i)});
        end
        tick();
        check("chg4_exit", {busy, ret_lo, ret_hi, credit}, 0);

        coin(1'b1); coin(1'b0); coin(1'b0);
        check("credit7", credit, 7);
        change_req = 1'b1; tick();
        tick(); check("chg7_hi", {ret_hi, ret_lo, credit}, {2'b10, 4'd2});
        tick(); check("chg7_lo1", {ret_hi, ret_lo, credit}, {2'b01, 4'd1});
        tick(); check("chg7_lo2", {ret_hi, ret_lo, credit}, {2'b01, 4'd0});
        tick(); check("chg7_idle", {busy, ret_hi, ret_lo}, 0);

        coin(1'b1); coin(1'b1);
        check("credit10", credit, 10);
        coin(1'b1);
        check("ceiling_reject", {coin_reject, credit}, {1'b1, 4'd10});
        tick();
        check("reject_1cycle", coin_reject, 0);

        change_req = 1'b1; tick();
        tick(); tick();
        check("chg10_two_hi", {ret_hi, credit}, {1'b1, 4'd0});
        tick();
        check("chg10_idle", busy, 0);

        coin(1'b1); coin(1'b0);
        vend_sel = 1'b0; vend_req = 1'b1; coin_valid = 1'b1; coin_type = 1'b0; tick();
        check("coin_vend_same", {vend_pulse, coin_reject, credit}, {2'b11, 4'd4});
        tick();
        check("coin_vend_total", vend_total, 2);

        coin(1'b1); coin(1'b0);
        vend_sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vend_req = 1'b1; tick();
            check("vend1_pulse", {vend_pulse, vend_id, credit}, {2'b11, 4'(8 - 2 * i)});
            tick();
        end
        check("vend1_empty", empty, 2'b10);
        vend_req = 1'b1; tick();
        check("vend1_fail_empty", {vend_fail, vend_pulse, busy, credit}, {3'b100, 4'd4});
        check("vend1_total", vend_total, 5);
        restock = 1'b1; tick();
        check("restock_empty", empty, 0);

        vend_req = 1'b1; restock = 1'b1; tick();
        check("restock_vend", {vend_pulse, empty, credit}, {3'b100, 4'd2});
        tick();
        vend_sel = 1'b0; vend_req = 1'b1; tick();
        check("vend_credit2", {vend_pulse, credit}, {1'b1, 4'd0});
        tick();
        vend_req = 1'b1; tick();
        check("fail_no_credit", {vend_fail, vend_pulse, credit}, {2'b10, 4'd0});
        change_req = 1'b1; tick();
        check("chg_zero_credit", {busy, ret_lo, ret_hi}, 0);

        reset = 1'b1; #2; reset = 1'b0;
        coin(1'b1); coin(1'b0); coin(1'b0); coin(1'b0); coin(1'b0);
        check("auto_credit9", a_credit, 9);
        vend_sel = 1'b0; vend_req = 1'b1; tick();
        check("auto_vend", {a_vend_pulse, a_credit}, {1'b1, 4'd7});
        tick(); check("auto_to_change", {a_busy, a_ret_hi, a_ret_lo, a_credit}, {3'b100, 4'd7});
        tick(); check("auto_hi", {a_ret_hi, a_ret_lo, a_credit}, {2'b10, 4'd2});
        tick(); check("auto_lo1", {a_ret_hi, a_ret_lo, a_credit}, {2'b01, 4'd1});
        tick(); check("auto_lo2", {a_ret_hi, a_ret_lo, a_credit}, {2'b01, 4'd0});
        tick(); check("auto_idle", a_busy, 0);
        check("noauto_idle", {busy, credit}, {1'b0, 4'd7});

        coin(1'b0);
        change_req = 1'b1; tick();
        tick();
        check("pre_reset_credit3", {busy, ret_hi, credit}, {2'b11, 4'd3});
        #2; reset = 1'b1; #1;
        check("async_reset", {credit, ret_lo, ret_hi, busy, empty}, 0);
        check("async_reset_total", vend_total, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
